// File: rtl/drawbridge_ctrl_v2_if.sv
// ============================================================================
// Module  : drawbridge_ctrl_v2_if
// Brief   : Sensor/actuator bundle between bridge field I/O and the controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface drawbridge_ctrl_v2_if #(
    parameter int CNT_W  = 4,
    parameter int N_BOAT = 2
);
    logic              cain;
    logic              cao;
    logic              md;
    logic              pb;
    logic [N_BOAT-1:0] bs;
    logic              h;
    logic              l;
    logic              al_ack;
    logic              mt;
    logic              dir;
    logic              al;
    logic              tfl;
    logic [2:0]        state;
    logic [CNT_W-1:0]  car_cnt;

    // Field side: sensors, push button and operator acknowledge.
    modport master (
        output cain, cao, md, pb, bs, h, l, al_ack,
        input  mt, dir, al, tfl, state, car_cnt
    );

    // Controller side.
    modport slave (
        input  cain, cao, md, pb, bs, h, l, al_ack,
        output mt, dir, al, tfl, state, car_cnt
    );
endinterface

`default_nettype wire

// File: rtl/drawbridge_ctrl_v2.sv
// ============================================================================
// Module  : drawbridge_ctrl_v2
// Brief   : Drawbridge controller with car counting, travel watchdog and alarm.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module drawbridge_ctrl_v2 #(
    parameter int CNT_W      = 4,
    parameter int N_BOAT     = 2,
    parameter int TRAVEL_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    drawbridge_ctrl_v2_if.slave  bus
);
    localparam int               TMR_W    = (TRAVEL_MAX > 2) ? $clog2(TRAVEL_MAX) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_FLAT     = 3'd0,
        ST_LIFTING  = 3'd1,
        ST_UPRIGHT  = 3'd2,
        ST_LOWERING = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pend_q,  pend_d;
    logic             pb_q;
    logic             al_q,    al_d;
    logic             mt_q,    mt_d;
    logic             dir_q,   dir_d;
    logic             tfl_q,   tfl_d;

    logic any_boat, pb_edge, raise_req, lower_req;
    logic inc, dec, ovf, udf, al_set;

    assign any_boat  = |bus.bs;
    assign pb_edge   = bus.pb & ~pb_q;
    assign raise_req = bus.md ? pb_edge : any_boat;
    assign lower_req = bus.md ? pb_edge : ~any_boat;
    assign inc       = bus.cain & ~bus.cao;
    assign dec       = bus.cao & ~bus.cain;
    assign ovf       = inc && (cnt_q == CNT_MAX);
    assign udf       = dec && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FLAT;
            timer_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pb_q    <= 1'b0;
            al_q    <= 1'b0;
            mt_q    <= 1'b0;
            dir_q   <= 1'b0;
            tfl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pb_q    <= bus.pb;
            al_q    <= al_d;
            mt_q    <= mt_d;
            dir_q   <= dir_d;
            tfl_q   <= tfl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;

        if (inc && !ovf)
            cnt_d = cnt_q + 1'b1;
        else if (dec && !udf)
            cnt_d = cnt_q - 1'b1;

        case (state_q)
            ST_FLAT: begin
                if (!bus.md && !any_boat)
                    pend_d = 1'b0;
                else if (raise_req)
                    pend_d = 1'b1;
                // Lift decision uses the occupancy before this cycle's update.
                if (pend_q && (cnt_q == '0) && !bus.cain)
                    state_d = ST_LIFTING;
            end
            ST_LIFTING: begin
                if (bus.h)
                    state_d = ST_UPRIGHT;
                else if (timer_q == TMR_LAST)
                    state_d = ST_FAULT;
            end
            ST_UPRIGHT: begin
                if (lower_req)
                    state_d = ST_LOWERING;
            end
            ST_LOWERING: begin
                if (bus.l)
                    state_d = ST_FLAT;
                else if (!bus.md && any_boat)
                    state_d = ST_LIFTING;
                else if (timer_q == TMR_LAST)
                    state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (bus.al_ack && bus.md)
                    state_d = ST_LOWERING;
            end
            default: state_d = ST_FLAT;
        endcase

        if (state_d != ST_FLAT)
            pend_d = 1'b0;

        if (state_d != state_q)
            timer_d = '0;
        else if (state_q == ST_LIFTING || state_q == ST_LOWERING)
            timer_d = timer_q + 1'b1;

        al_set = (bus.h & bus.l)
               | (bus.h & (state_q == ST_LOWERING))
               | (bus.l & (state_q == ST_UPRIGHT))
               | ovf | udf
               | ((state_d == ST_FAULT) && (state_q != ST_FAULT));

        // Set beats acknowledge; FAULT holds the alarm until it is left.
        if (al_set)
            al_d = 1'b1;
        else if (bus.al_ack && (state_q != ST_FAULT))
            al_d = 1'b0;
        else
            al_d = al_q;

        mt_d  = (state_d == ST_LIFTING) || (state_d == ST_LOWERING);
        dir_d = (state_d == ST_LIFTING);
        tfl_d = (state_d == ST_FLAT) && !pend_d;
    end

    assign bus.state   = state_q;
    assign bus.mt      = mt_q;
    assign bus.dir     = dir_q;
    assign bus.al      = al_q;
    assign bus.tfl     = tfl_q;
    assign bus.car_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_drawbridge_ctrl_v2.sv
// ============================================================================
// Module  : tb_drawbridge_ctrl_v2
// Brief   : Directed scoreboard bench for drawbridge_ctrl_v2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drawbridge_ctrl_v2;
    localparam int CNT_W      = 4;
    localparam int N_BOAT     = 2;
    localparam int TRAVEL_MAX = 16;

    localparam int S_FLAT = 0, S_LIFT = 1, S_UP = 2, S_LOW = 3, S_FAULT = 4;
    localparam int X = -1;

    typedef struct {
        int    cyc;
        string nm;
        int    st, mt, dir, al, tfl, cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    drawbridge_ctrl_v2_if #(.CNT_W(CNT_W), .N_BOAT(N_BOAT)) bus_if ();

    drawbridge_ctrl_v2 #(
        .CNT_W      (CNT_W),
        .N_BOAT     (N_BOAT),
        .TRAVEL_MAX (TRAVEL_MAX)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int st, input int mt, input int dir,
                              input int al, input int tfl, input int cnt);
        exp_t e;
        e.cyc = cyc; e.nm = nm;
        e.st = st; e.mt = mt; e.dir = dir; e.al = al; e.tfl = tfl; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input int got, input int want);
        if (want >= 0) begin
            checks++;
            if (got != want) begin
                failures++;
                $display("FAIL %s.%s got=%0d exp=%0d (cycle %0d)", nm, fld, got, want, cyc);
            end
        end
    endtask

    // Monitor: outputs are presented every cycle and sampled on the falling edge.
    initial begin
        checks   = 0;
        failures = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                cmp(e.nm, "state", int'(bus_if.state),   e.st);
                cmp(e.nm, "mt",    int'(bus_if.mt),      e.mt);
                cmp(e.nm, "dir",   int'(bus_if.dir),     e.dir);
                cmp(e.nm, "al",    int'(bus_if.al),      e.al);
                cmp(e.nm, "tfl",   int'(bus_if.tfl),     e.tfl);
                cmp(e.nm, "cnt",   int'(bus_if.car_cnt), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        bus_if.cain = 0; bus_if.cao = 0; bus_if.md = 0; bus_if.pb = 0;
        bus_if.bs = '0; bus_if.h = 0; bus_if.l = 1; bus_if.al_ack = 0;

        tick(); expect_out("reset", S_FLAT, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        tick(); expect_out("idle", S_FLAT, 0, 0, 0, 1, 0);

        // Auto lift and lower
        bus_if.bs = 2'b01;
        tick(); expect_out("auto_pend", S_FLAT, 0, X, 0, 0, 0);
        tick(); expect_out("auto_lift", S_LIFT, 1, 1, 0, 0, 0);
        bus_if.l = 0;
        tick(); expect_out("auto_lifting", S_LIFT, 1, 1, 0, 0, 0);
        bus_if.h = 1;
        tick(); expect_out("auto_up", S_UP, 0, X, 0, 0, 0);
        tick(); expect_out("auto_up_hold", S_UP, 0, X, 0, 0, 0);
        bus_if.bs = 2'b00;
        tick(); expect_out("auto_lower", S_LOW, 1, 0, 0, 0, 0);
        bus_if.h = 0;
        tick(); expect_out("auto_lowering", S_LOW, 1, 0, 0, 0, 0);
        bus_if.l = 1;
        tick(); expect_out("auto_flat", S_FLAT, 0, 0, 0, 1, 0);

        // Cars on bridge block the lift
        bus_if.cain = 1; tick(); expect_out("car_in1", S_FLAT, 0, X, 0, 1, 1);
        tick(); expect_out("car_in2", S_FLAT, 0, X, 0, 1, 2);
        bus_if.cain = 0; bus_if.bs = 2'b10;
        tick(); expect_out("cars_pend", S_FLAT, 0, X, 0, 0, 2);
        tick(); expect_out("cars_block", S_FLAT, 0, X, 0, 0, 2);
        bus_if.cao = 1; tick(); expect_out("car_out1", S_FLAT, 0, X, 0, 0, 1);
        tick(); expect_out("car_out2", S_FLAT, 0, X, 0, 0, 0);
        bus_if.cao = 0;
        tick(); expect_out("cars_lift", S_LIFT, 1, 1, 0, 0, 0);

        // Reversal during lowering, then watchdog from the restarted timer
        bus_if.l = 0; bus_if.h = 1;
        tick(); expect_out("rev_up", S_UP, 0, X, 0, 0, 0);
        bus_if.bs = 2'b00;
        tick(); expect_out("rev_lower", S_LOW, 1, 0, 0, 0, 0);
        bus_if.h = 0;
        tick(); expect_out("rev_lowering1", S_LOW, 1, 0, 0, 0, 0);
        tick(); expect_out("rev_lowering2", S_LOW, 1, 0, 0, 0, 0);
        bus_if.bs = 2'b01;
        tick(); expect_out("reversal", S_LIFT, 1, 1, 0, 0, 0);
        for (int i = 1; i < TRAVEL_MAX; i++) begin
            tick(); expect_out("wd_lifting", S_LIFT, 1, 1, 0, 0, 0);
        end
        tick(); expect_out("wd_fault", S_FAULT, 0, X, 1, 0, 0);
        bus_if.al_ack = 1;
        tick(); expect_out("fault_ack_auto", S_FAULT, 0, X, 1, 0, 0);
        bus_if.md = 1; bus_if.bs = 2'b00;
        tick(); expect_out("fault_ack_man", S_LOW, 1, 0, 1, 0, 0);
        bus_if.al_ack = 0; bus_if.l = 1;
        tick(); expect_out("fault_flat", S_FLAT, 0, 0, 1, 1, 0);
        bus_if.al_ack = 1;
        tick(); expect_out("ack_flat", S_FLAT, 0, 0, 0, 1, 0);
        bus_if.al_ack = 0;

        // Manual: one lift per push-button edge
        bus_if.pb = 1;
        tick(); expect_out("man_pend", S_FLAT, 0, X, 0, 0, 0);
        tick(); expect_out("man_lift", S_LIFT, 1, 1, 0, 0, 0);
        tick(); expect_out("man_held", S_LIFT, 1, 1, 0, 0, 0);
        bus_if.pb = 0; bus_if.l = 0; bus_if.h = 1;
        tick(); expect_out("man_up", S_UP, 0, X, 0, 0, 0);
        tick(); expect_out("man_up_hold", S_UP, 0, X, 0, 0, 0);
        bus_if.pb = 1;
        tick(); expect_out("man_lower", S_LOW, 1, 0, 0, 0, 0);
        bus_if.pb = 0;
        tick(); expect_out("h_in_lowering", S_LOW, 1, 0, 1, 0, 0);
        bus_if.h = 0;
        tick(); expect_out("lowering_al", S_LOW, 1, 0, 1, 0, 0);
        bus_if.l = 1;
        tick(); expect_out("man_flat", S_FLAT, 0, 0, 1, 1, 0);
        bus_if.al_ack = 1;
        tick(); expect_out("ack2", S_FLAT, 0, 0, 0, 1, 0);
        bus_if.al_ack = 0;

        // Counter underflow
        bus_if.cao = 1;
        tick(); expect_out("underflow", S_FLAT, 0, 0, 1, 1, 0);
        bus_if.cao = 0; bus_if.al_ack = 1;
        tick(); expect_out("ack3", S_FLAT, 0, 0, 0, 1, 0);
        bus_if.al_ack = 0;

        // Asynchronous reset while lifting
        bus_if.pb = 1;
        tick(); expect_out("pre_rst_pend", S_FLAT, 0, X, 0, 0, 0);
        bus_if.pb = 0;
        tick(); expect_out("pre_rst_lift", S_LIFT, 1, 1, 0, 0, 0);
        bus_if.l = 0;
        tick();
        rst_n = 1'b0;
        expect_out("async_rst", S_FLAT, 0, 0, 0, 1, 0);
        tick(); expect_out("rst_held", S_FLAT, 0, 0, 0, 1, 0);
        rst_n = 1'b1; bus_if.l = 1; bus_if.md = 0;

        // Counter saturation and alarm tie-breaking
        bus_if.cain = 1;
        for (int i = 1; i <= 15; i++) begin
            tick(); expect_out("count_up", S_FLAT, 0, 0, 0, 1, i);
        end
        tick(); expect_out("overflow", S_FLAT, 0, 0, 1, 1, 15);
        bus_if.cao = 1;
        tick(); expect_out("both_hold", S_FLAT, 0, 0, 1, 1, 15);
        bus_if.cain = 0; bus_if.cao = 0; bus_if.al_ack = 1;
        tick(); expect_out("ack4", S_FLAT, 0, 0, 0, 1, 15);
        bus_if.h = 1;
        tick(); expect_out("hl_set_wins", S_FLAT, 0, 0, 1, 1, 15);
        bus_if.h = 0;
        tick(); expect_out("ack5", S_FLAT, 0, 0, 0, 1, 15);
        bus_if.al_ack = 0;

        tick(); tick();
        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
